// File: rtl/sgm_path_scheduler.sv
// Left-to-right SGM path scheduler: walks one frame in raster order, feeds the 1D
// path aggregator with the previous pixel's costs and drains results through a one-entry output stage.

module aggregate_path_v #(
    parameter int MAX_DISP   = 16,
    parameter int P1_PENALTY = 8,
    parameter int P2_PENALTY = 128
) (
    input  logic [MAX_DISP*16-1:0] cost_i,
    input  logic [MAX_DISP*16-1:0] prev_i,
    input  logic [15:0]            min_prev_i,
    input  logic                   path_start_i,
    output logic [MAX_DISP*16-1:0] cost_o,
    output logic [15:0]            min_o
);
    localparam logic [15:0] P1 = P1_PENALTY[15:0];
    localparam logic [15:0] P2 = P2_PENALTY[15:0];

    logic [MAX_DISP-1:0][15:0] lane_l;
    logic [15:0]               far_c;

    assign far_c = min_prev_i + P2;

    for (genvar d = 0; d < MAX_DISP; d++) begin : g_lane
        logic [15:0] same_c, lo_c, hi_c, m_a, m_b, best;
        assign same_c = prev_i[d*16 +: 16];
        // Missing neighbours at the disparity edges never win the minimum.
        if (d > 0) begin : g_lo
            assign lo_c = prev_i[(d-1)*16 +: 16] + P1;
        end else begin : g_lo0
            assign lo_c = 16'hFFFF;
        end
        if (d < MAX_DISP-1) begin : g_hi
            assign hi_c = prev_i[(d+1)*16 +: 16] + P1;
        end else begin : g_hiN
            assign hi_c = 16'hFFFF;
        end
        assign m_a  = (same_c < lo_c) ? same_c : lo_c;
        assign m_b  = (hi_c < far_c) ? hi_c : far_c;
        assign best = (m_a < m_b) ? m_a : m_b;
        assign lane_l[d] = path_start_i ? cost_i[d*16 +: 16]
                                        : cost_i[d*16 +: 16] + best - min_prev_i;
    end

    assign cost_o = lane_l;

    always_comb begin
        min_o = lane_l[0];
        for (int d = 1; d < MAX_DISP; d++)
            if (lane_l[d] < min_o) min_o = lane_l[d];
    end
endmodule

module sgm_path_scheduler #(
    parameter int MAX_DISP   = 16,
    parameter int P1_PENALTY = 8,
    parameter int P2_PENALTY = 128,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAX_DISP*16-1:0] in_cost_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAX_DISP*16-1:0] out_cost_flat,
    output logic [15:0]            out_min_cost,
    output logic                   out_last_in_row,
    output logic                   out_last_in_frame
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                  state_q;
    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic [MAX_DISP*16-1:0]  prev_q, out_cost_q, next_cost_d;
    logic [15:0]             prev_min_q, out_min_q, next_min_d;
    logic                    out_valid_q, last_row_q, last_frame_q;
    logic                    busy_q, done_q;
    logic                    accept, last_col, last_pix;

    aggregate_path_v #(
        .MAX_DISP  (MAX_DISP),
        .P1_PENALTY(P1_PENALTY),
        .P2_PENALTY(P2_PENALTY)
    ) u_agg (
        .cost_i      (in_cost_flat),
        .prev_i      (prev_q),
        .min_prev_i  (prev_min_q),
        .path_start_i(col_q == '0),
        .cost_o      (next_cost_d),
        .min_o       (next_min_d)
    );

    assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_pix = last_col && (row_q == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            prev_q       <= '0;
            prev_min_q   <= '0;
            out_cost_q   <= '0;
            out_min_q    <= '0;
            out_valid_q  <= 1'b0;
            last_row_q   <= 1'b0;
            last_frame_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                    col_q   <= '0;
                    row_q   <= '0;
                end
                S_RUN: if (accept && last_pix) state_q <= S_FLUSH;
                S_FLUSH: if (out_valid_q && out_ready) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase

            // A drain and a fresh accept in the same cycle reload the stage with no bubble.
            if (accept) begin
                out_cost_q   <= next_cost_d;
                out_min_q    <= next_min_d;
                prev_q       <= next_cost_d;
                prev_min_q   <= next_min_d;
                last_row_q   <= last_col;
                last_frame_q <= last_pix;
                out_valid_q  <= 1'b1;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign busy              = busy_q;
    assign frame_done        = done_q;
    assign out_valid         = out_valid_q;
    assign out_cost_flat     = out_cost_q;
    assign out_min_cost      = out_min_q;
    assign out_last_in_row   = last_row_q;
    assign out_last_in_frame = last_frame_q;
endmodule

// File: tb/tb_sgm_path_scheduler.sv
// Random and directed stimulus for sgm_path_scheduler, checked against a
// transaction-level SGM path model with an expected-output queue.

module tb_sgm_path_scheduler;
    localparam int ND = 4;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int P1 = 8;
    localparam int P2 = 128;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, out_ready;
    logic          busy, frame_done, in_ready, out_valid;
    logic          out_last_in_row, out_last_in_frame;
    logic [ND*16-1:0] in_cost_flat, out_cost_flat;
    logic [15:0]   out_min_cost;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    typedef struct {
        logic [63:0] c;
        logic [15:0] m;
        bit          lr;
        bit          lf;
    } exp_t;

    exp_t        q[$];
    int          m_state;   // 0 idle, 1 run, 2 flush, 3 done
    int          m_col, m_row;
    logic [15:0] m_prev[ND];
    logic [15:0] m_min;

    sgm_path_scheduler #(
        .MAX_DISP(ND), .P1_PENALTY(P1), .P2_PENALTY(P2),
        .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_cost_flat(in_cost_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_cost_flat(out_cost_flat),
        .out_min_cost(out_min_cost), .out_last_in_row(out_last_in_row),
        .out_last_in_frame(out_last_in_frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_pixel(input logic [63:0] cost);
        exp_t        e;
        logic [15:0] c, best, cand, l, mn;
        mn = 16'hFFFF;
        for (int d = 0; d < ND; d++) begin
            c = cost[d*16 +: 16];
            if (m_col == 0) begin
                l = c;
            end else begin
                best = m_prev[d];
                if (d > 0)    begin cand = m_prev[d-1] + 16'(P1); if (cand < best) best = cand; end
                if (d < ND-1) begin cand = m_prev[d+1] + 16'(P1); if (cand < best) best = cand; end
                cand = m_min + 16'(P2);
                if (cand < best) best = cand;
                l = c + best - m_min;
            end
            e.c[d*16 +: 16] = l;
            if (l < mn) mn = l;
        end
        e.m  = mn;
        e.lr = (m_col == W-1);
        e.lf = (m_col == W-1) && (m_row == H-1);
        return e;
    endfunction

    // One clock: drive inputs at posedge+1, check at posedge+2, advance the model, return at next posedge+1.
    task automatic step(input bit st, input bit iv, input logic [63:0] cost, input bit ordy);
        bit   acc, drn;
        exp_t e;
        start = st; in_valid = iv; in_cost_flat = cost; out_ready = ordy;
        #1;
        chk("busy",  {63'd0, busy},       {63'd0, (m_state == 1 || m_state == 2)});
        chk("fdone", {63'd0, frame_done}, {63'd0, (m_state == 3)});
        chk("ovld",  {63'd0, out_valid},  {63'd0, (q.size() != 0)});
        chk("irdy",  {63'd0, in_ready},   {63'd0, (m_state == 1 && (q.size() == 0 || ordy))});
        if (q.size() != 0) begin
            chk("ocost",  out_cost_flat,               q[0].c);
            chk("omin",   {48'd0, out_min_cost},       {48'd0, q[0].m});
            chk("olrow",  {63'd0, out_last_in_row},    {63'd0, q[0].lr});
            chk("olfrm",  {63'd0, out_last_in_frame},  {63'd0, q[0].lf});
        end
        acc = iv && m_state == 1 && (q.size() == 0 || ordy);
        drn = (q.size() != 0) && ordy;
        if (drn) void'(q.pop_front());
        case (m_state)
            0: if (st) begin m_state = 1; m_col = 0; m_row = 0; end
            1: if (acc && m_col == W-1 && m_row == H-1) m_state = 2;
            2: if (drn) begin m_state = 3; frames++; end
            default: m_state = 0;
        endcase
        if (acc) begin
            e = model_pixel(cost);
            q.push_back(e);
            for (int d = 0; d < ND; d++) m_prev[d] = e.c[d*16 +: 16];
            m_min = e.m;
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rnd_cost();
        logic [63:0] v;
        for (int d = 0; d < ND; d++) v[d*16 +: 16] = 16'($urandom_range(0, 511));
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cost_flat = '0;
        m_state = 0; m_col = 0; m_row = 0; m_min = '0;
        for (int d = 0; d < ND; d++) m_prev[d] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovld", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_irdy", {63'd0, in_ready}, 64'd0);
        chk("rst_fdone", {63'd0, frame_done}, 64'd0);
        chk("rst_ocost", out_cost_flat, 64'd0);
        chk("rst_omin", {48'd0, out_min_cost}, 64'd0);
        rst_n = 1'b1;

        // Directed frame
        step(1, 0, '0, 1);
        step(0, 1, {16'd40, 16'd30, 16'd20, 16'd10}, 0);
        chk("p0_cost", out_cost_flat, {16'd40, 16'd30, 16'd20, 16'd10});
        chk("p0_min", {48'd0, out_min_cost}, 64'd10);
        step(0, 1, {16'd5, 16'd5, 16'd5, 16'd5}, 1);
        chk("p1_cost", out_cost_flat, {16'd33, 16'd23, 16'd13, 16'd5});
        chk("p1_min", {48'd0, out_min_cost}, 64'd5);
        chk("p1_lrow", {63'd0, out_last_in_row}, 64'd0);
        step(0, 1, rnd_cost(), 1);
        step(0, 1, rnd_cost(), 1);
        chk("p3_lrow", {63'd0, out_last_in_row}, 64'd1);
        step(0, 1, {16'd1, 16'd9, 16'd3, 16'd7}, 1);
        chk("p4_cost", out_cost_flat, {16'd1, 16'd9, 16'd3, 16'd7});
        chk("p4_min", {48'd0, out_min_cost}, 64'd1);
        repeat (3) step(0, 1, {16'd2, 16'd2, 16'd2, 16'd2}, 0);
        step(0, 1, {16'd2, 16'd2, 16'd2, 16'd2}, 1);
        step(1, 1, rnd_cost(), 1);
        step(0, 1, rnd_cost(), 1);
        chk("p7_lfrm", {63'd0, out_last_in_frame}, 64'd1);
        step(0, 0, '0, 1);
        chk("done_pulse", {63'd0, frame_done}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // Reset while pixel 2 is presented
        step(1, 0, '0, 1);
        step(0, 1, rnd_cost(), 1);
        step(0, 1, rnd_cost(), 1);
        in_valid = 1'b1; rst_n = 1'b0;
        #1;
        chk("mrst_ovld", {63'd0, out_valid}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_irdy", {63'd0, in_ready}, 64'd0);
        q.delete();
        m_state = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random frames with random backpressure
        for (int n = 0; n < 1500; n++) begin
            step((m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 9) < 7, rnd_cost(), $urandom_range(0, 9) < 7);
        end
        chk("frames_seen", {63'd0, frames >= 5}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
